// File: rtl/fir_tdm_filter_if.sv
// rtl/fir_tdm_filter_if.sv - sample, result and coefficient bus of the TDM FIR filter
//
// Purpose: bundles the frame input handshake, the result output handshake and the
// coefficient write port of fir_tdm_filter.
// Signals:
//   in_data   CHANNELS*WIDTH  one sample per channel, channel 0 in the LSBs
//   in_valid  1               frame offered by the producer
//   in_ready  1               filter can accept a frame
//   bypass    1               pass the frame through unfiltered (sampled on accept)
//   out_data  CHANNELS*WIDTH  filtered frame
//   out_valid 1               out_data valid, held until taken
//   out_ready 1               consumer takes the frame
//   coef_wr   1               coefficient write strobe
//   coef_addr log2(TAPS)      tap index, 0 = newest sample
//   coef_data COEF_WIDTH      coefficient, shared by all channels
// Modports: master drives frames/coefficients, slave is the filter.
interface fir_tdm_filter_if #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 16,
    parameter int CHANNELS   = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic                      bypass;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      coef_wr;
    logic [$clog2(TAPS)-1:0]   coef_addr;
    logic [COEF_WIDTH-1:0]     coef_data;

    modport master (
        output in_data, in_valid, bypass, out_ready, coef_wr, coef_addr, coef_data,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, bypass, out_ready, coef_wr, coef_addr, coef_data,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/fir_tdm_filter.sv
// rtl/fir_tdm_filter.sv - time-multiplexed multi-channel FIR filter with one shared MAC
//
// Purpose: filters a frame of CHANNELS samples with a TAPS-tap FIR whose coefficients
// are loaded at runtime. One multiply-accumulate per clock, channel-major/tap-minor,
// followed by round-half-up and saturation to WIDTH bits. Bypass returns the frame as-is.
// Ports:
//   CLOCK_50  in  clock, all logic on the rising edge
//   reset_n   in  synchronous active-low reset
//   bus       fir_tdm_filter_if.slave (frame in, result out, coefficient writes)
module fir_tdm_filter #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 16,
    parameter int CHANNELS   = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    fir_tdm_filter_if.slave  bus
);
    localparam int AW    = $clog2(TAPS);
    localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW    = WIDTH + COEF_WIDTH;
    localparam int ACC_W = PW + AW;

    localparam logic signed [ACC_W-1:0]      RND      = ACC_W'(1) << (COEF_WIDTH - 2);
    localparam logic signed [ACC_W-1:0]      SAT_MAX  = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]      SAT_MIN  = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic        [COEF_WIDTH-1:0] COEF_ONE = {1'b0, {(COEF_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                    r_state;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [CHANNELS*WIDTH-1:0] r_out_data;
    logic signed [WIDTH-1:0]   r_dline [CHANNELS][TAPS];
    logic signed [COEF_WIDTH-1:0] r_coef [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [AW-1:0]             r_tap;
    logic [CHW-1:0]            r_ch;
    logic                      r_flush;   // all taps done, last channel result pending
    logic                      r_bypass;  // bypass frame waiting to be copied to out_data

    logic signed [WIDTH-1:0]   w_x;
    logic signed [PW-1:0]      w_prod;
    logic signed [ACC_W-1:0]   w_addend;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_rnd;
    logic signed [ACC_W-1:0]   w_shift;
    logic [WIDTH-1:0]          w_result;
    logic [CHW-1:0]            w_res_ch;
    logic                      w_store;
    logic                      w_last_tap;
    logic                      w_last_ch;

    assign w_x        = r_dline[r_ch][r_tap];
    assign w_prod     = PW'(w_x) * PW'(r_coef[r_tap]);
    assign w_addend   = ACC_W'(w_prod);
    // Tap 0 starts a fresh sum, so the accumulator clear between channels is free.
    assign w_acc_next = (r_tap == '0) ? w_addend : r_acc + w_addend;

    assign w_rnd      = r_acc + RND;
    assign w_shift    = w_rnd >>> (COEF_WIDTH - 1);
    assign w_result   = (w_shift > SAT_MAX) ? SAT_MAX[WIDTH-1:0] :
                        (w_shift < SAT_MIN) ? SAT_MIN[WIDTH-1:0] : w_shift[WIDTH-1:0];

    assign w_last_tap = (r_tap == AW'(TAPS - 1));
    assign w_last_ch  = (r_ch == CHW'(CHANNELS - 1));
    // A channel's sum is complete one edge after its last tap: either when the next
    // channel starts (tap 0 of ch>0) or in the final flush step.
    assign w_res_ch   = r_flush ? r_ch : r_ch - 1'b1;
    assign w_store    = r_flush || ((r_tap == '0) && (r_ch != '0));

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_acc       <= '0;
            r_tap       <= '0;
            r_ch        <= '0;
            r_flush     <= 1'b0;
            r_bypass    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    r_dline[c][t] <= '0;
                end
            end
            for (int t = 0; t < TAPS; t++) begin
                r_coef[t] <= (t == 0) ? COEF_ONE : '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.coef_wr) begin
                        r_coef[bus.coef_addr] <= bus.coef_data;
                    end
                    if (bus.in_valid) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            for (int t = TAPS - 1; t > 0; t--) begin
                                r_dline[c][t] <= r_dline[c][t-1];
                            end
                            r_dline[c][0] <= bus.in_data[c*WIDTH +: WIDTH];
                        end
                        r_in_ready <= 1'b0;
                        r_acc      <= '0;
                        r_tap      <= '0;
                        r_ch       <= '0;
                        r_flush    <= 1'b0;
                        if (bus.bypass) begin
                            r_bypass <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_MAC;
                        end
                    end
                end
                S_MAC: begin
                    if (w_store) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            if (w_res_ch == CHW'(c)) begin
                                r_out_data[c*WIDTH +: WIDTH] <= w_result;
                            end
                        end
                    end
                    if (r_flush) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (w_last_tap) begin
                            r_tap <= '0;
                            if (w_last_ch) begin
                                r_flush <= 1'b1;
                            end else begin
                                r_ch <= r_ch + 1'b1;
                            end
                        end else begin
                            r_tap <= r_tap + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (r_bypass) begin
                        // Tap 0 of every delay line is the frame just accepted.
                        for (int c = 0; c < CHANNELS; c++) begin
                            r_out_data[c*WIDTH +: WIDTH] <= r_dline[c][0];
                        end
                        r_out_valid <= 1'b1;
                        r_bypass    <= 1'b0;
                    end else if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_fir_tdm_filter.sv
// tb/tb_fir_tdm_filter.sv - self-checking bench for fir_tdm_filter
module tb_fir_tdm_filter;
    localparam int W  = 16;
    localparam int CW = 16;
    localparam int T  = 16;
    localparam int C  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fir_tdm_filter_if #(.WIDTH(W), .COEF_WIDTH(CW), .TAPS(T), .CHANNELS(C)) bus ();

    fir_tdm_filter #(.WIDTH(W), .COEF_WIDTH(CW), .TAPS(T), .CHANNELS(C)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          hist  [C][T];
    int          coefm [T];
    logic        m_live = 1'b0;
    logic        m_ready = 1'b1;
    logic        m_valid = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_exp = '0;

    function automatic logic [15:0] filt(input int ch);
        longint s = 0;
        for (int t = 0; t < T; t++) s += longint'(hist[ch][t]) * longint'(coefm[t]);
        s = (s + 16384) >>> 15;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    // Checks outputs against the model, then advances the model for the coming edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("model_in_ready", {31'b0, bus.in_ready}, {31'b0, m_ready});
            chk("model_out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
            if (m_valid) chk("model_out_data", bus.out_data, m_exp);
        end
        if (!reset_n) begin
            m_live = 1'b1; m_ready = 1'b1; m_valid = 1'b0; m_wait = 0;
            for (int c = 0; c < C; c++) for (int t = 0; t < T; t++) hist[c][t] = 0;
            for (int t = 0; t < T; t++) coefm[t] = (t == 0) ? 32767 : 0;
        end else if (m_live) begin
            if (m_ready) begin
                if (bus.coef_wr) coefm[bus.coef_addr] = int'($signed(bus.coef_data));
                if (bus.in_valid) begin
                    for (int c = 0; c < C; c++) begin
                        for (int t = T - 1; t > 0; t--) hist[c][t] = hist[c][t-1];
                        hist[c][0] = int'($signed(bus.in_data[c*W +: W]));
                    end
                    if (bus.bypass) begin
                        m_exp  = bus.in_data;
                        m_wait = 1;
                    end else begin
                        for (int c = 0; c < C; c++) m_exp[c*W +: W] = filt(c);
                        m_wait = C * T + 1;
                    end
                    m_ready = 1'b0;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_valid = 1'b1;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end
    end

    // ---------------- stimulus tasks (entered just after a rising edge) ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic write_coef(input int addr, input logic [15:0] data);
        bus.coef_wr = 1'b1; bus.coef_addr = 4'(addr); bus.coef_data = data;
        @(posedge clk); #1;
        bus.coef_wr = 1'b0;
    endtask

    task automatic accept_frame(input logic [15:0] a, input logic [15:0] b, input logic byp);
        logic r;
        logic ok = 1'b0;
        bus.in_data = {b, a}; bus.bypass = byp; bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); r = bus.in_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1'b1; break; end
        end
        bus.in_valid = 1'b0; bus.bypass = 1'b0;
        if (!ok) begin checks++; errors++; $display("FAIL accept_timeout: frame not accepted"); end
    endtask

    task automatic wait_valid(output logic [31:0] d, output int lat);
        logic ok = 1'b0;
        lat = 0; d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin d = bus.out_data; ok = 1'b1; break; end
            lat++;
            @(posedge clk); #1;
        end
        if (!ok) begin checks++; errors++; $display("FAIL out_timeout: out_valid never rose"); end
    endtask

    task automatic get_out(output logic [31:0] d, output int lat);
        wait_valid(d, lat);
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic byp,
                       output logic [31:0] d, output int lat);
        accept_frame(a, b, byp);
        get_out(d, lat);
    endtask

    logic [31:0] d, hold_d;
    int          lat;

    initial begin
        bus.in_data = '0; bus.in_valid = 1'b0; bus.bypass = 1'b0; bus.out_ready = 1'b1;
        bus.coef_wr = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'h0);
        @(posedge clk); #1;

        // 1: identity filter and latency
        run(16'h1000, 16'h2000, 1'b0, d, lat);
        chk("t1_ch0", {16'h0, d[15:0]}, 32'h1000);
        chk("t1_ch1", {16'h0, d[31:16]}, 32'h2000);
        chk("t1_latency", lat, 33);

        // 2: moving sum ramp
        do_reset();
        for (int t = 0; t < T; t++) write_coef(t, 16'h0800);
        for (int k = 1; k <= 17; k++) begin
            run(16'h4000, 16'h4000, 1'b0, d, lat);
            chk("t2_ch0", {16'h0, d[15:0]}, (k <= 16) ? 32'(k * 32'h400) : 32'h4000);
            chk("t2_ch1", {16'h0, d[31:16]}, (k <= 16) ? 32'(k * 32'h400) : 32'h4000);
        end

        // 3: saturation both ways
        for (int t = 0; t < T; t++) write_coef(t, 16'h7FFF);
        for (int k = 0; k < 16; k++) run(16'h7FFF, 16'h7FFF, 1'b0, d, lat);
        chk("t3_pos_sat", d, 32'h7FFF7FFF);
        for (int k = 0; k < 16; k++) run(16'h8000, 16'h8000, 1'b0, d, lat);
        chk("t3_neg_sat", d, 32'h80008000);

        // 4: back-pressure in DONE with a frame pending
        do_reset();
        bus.out_ready = 1'b0;
        accept_frame(16'h0111, 16'h0222, 1'b0);
        wait_valid(hold_d, lat);
        chk("t4_first", hold_d, 32'h02220111);
        @(posedge clk); #1;
        bus.in_data = 32'h04440333; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_data", bus.out_data, hold_d);
            chk("t4_hold_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("t4_hold_ready", {31'b0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_release_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        get_out(d, lat);
        chk("t4_second", d, 32'h04440333);
        chk("t4_second_latency", lat, 33);

        // 5: bypass, then the bypassed frame seen at tap 1
        write_coef(0, 16'h0000);
        write_coef(1, 16'h7FFF);
        run(16'h1234, 16'hABCD, 1'b1, d, lat);
        chk("t5_bypass", d, 32'hABCD1234);
        chk("t5_bypass_latency", lat, 1);
        run(16'h0000, 16'h0000, 1'b0, d, lat);
        chk("t5_tap1_ch0", {16'h0, d[15:0]}, 32'h1234);
        chk("t5_tap1_ch1", {16'h0, d[31:16]}, 32'hABCE);

        // coef_wr during MAC is dropped
        do_reset();
        accept_frame(16'h0050, 16'h0060, 1'b0);
        write_coef(0, 16'h0000);
        get_out(d, lat);
        chk("t6_macwr_a", d, 32'h00600050);
        run(16'h0070, 16'h0080, 1'b0, d, lat);
        chk("t6_macwr_b", d, 32'h00800070);

        // 6: reset in the middle of MAC
        write_coef(0, 16'h4000);
        write_coef(3, 16'h7FFF);
        accept_frame(16'h0100, 16'h0200, 1'b0);
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("t6_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("t6_out_data", bus.out_data, 32'h0);
        @(posedge clk); #1;
        run(16'h0300, 16'h0400, 1'b0, d, lat);
        chk("t6_identity", d, 32'h04000300);
        write_coef(0, 16'h0000);
        for (int t = 2; t < T; t++) write_coef(t, 16'h7FFF);
        run(16'h0000, 16'h0000, 1'b0, d, lat);
        chk("t6_dline_zero", d, 32'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
